// File: rtl/l1a_tail_builder_if.sv
// Trailer-builder bus: checker status and L1A number in, trailer word stream out.
// The master side is the checker/FIFO-writer environment; the slave side is the builder.
interface l1a_tail_builder_if;
    logic        strt_tail;
    logic        data_ce;
    logic        do_err;
    logic        noend_error;
    logic        missing_dat;
    logic [23:0] l1a_num;
    logic        out_rdy;
    logic [15:0] tail_data;
    logic        tail_vld;
    logic        tail_last;
    logic        tail_busy;
    logic        tail_done;
    logic        tail_drop;

    modport master (
        output strt_tail, data_ce, do_err, noend_error, missing_dat, l1a_num, out_rdy,
        input  tail_data, tail_vld, tail_last, tail_busy, tail_done, tail_drop
    );

    modport slave (
        input  strt_tail, data_ce, do_err, noend_error, missing_dat, l1a_num, out_rdy,
        output tail_data, tail_vld, tail_last, tail_busy, tail_done, tail_drop
    );
endinterface

// File: rtl/l1a_tail_builder.sv
// Accumulates per-event word/error statistics, snapshots them on STRT_TAIL and
// streams the 4-word DMB event trailer over a valid/ready handshake.
module l1a_tail_builder (
    input  logic                  clk_i,
    input  logic                  rst_b_i,
    l1a_tail_builder_if.slave     bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEND0 = 3'd1,
        SEND1 = 3'd2,
        SEND2 = 3'd3,
        SEND3 = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t      state_q;

    logic [11:0] wc_q, wc_d;
    logic [3:0]  ec_q, ec_d;
    logic        noend_q, noend_d;
    logic        miss_q, miss_d;
    logic        ovf_q, ovf_d;
    logic        do_err_prev_q;

    logic [11:0] snap_l1a_hi_q;
    logic [11:0] snap_wc_q;
    logic [3:0]  snap_ec_q;
    logic        snap_noend_q;
    logic        snap_miss_q;
    logic        snap_ovf_q;

    logic [15:0] tail_data_q;
    logic        tail_vld_q;
    logic        tail_last_q;
    logic        tail_busy_q;
    logic        tail_done_q;
    logic        tail_drop_q;

    logic        snap_take;
    logic        wc_sat;
    logic        err_edge;

    assign snap_take = bus.strt_tail && (state_q == IDLE);

    // Updated statistics including this cycle's inputs; the snapshot latches these.
    always_comb begin
        wc_sat   = (wc_q == 12'hFFF);
        err_edge = bus.do_err && !do_err_prev_q && (ec_q != 4'hF);
        wc_d     = wc_q + {11'd0, (bus.data_ce && !wc_sat)};
        ovf_d    = ovf_q | (bus.data_ce & wc_sat);
        ec_d     = ec_q + {3'd0, err_edge};
        noend_d  = noend_q | bus.noend_error;
        miss_d   = miss_q | bus.missing_dat;
    end

    always_ff @(posedge clk_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            wc_q          <= '0;
            ec_q          <= '0;
            noend_q       <= 1'b0;
            miss_q        <= 1'b0;
            ovf_q         <= 1'b0;
            do_err_prev_q <= 1'b0;
            snap_l1a_hi_q <= '0;
            snap_wc_q     <= '0;
            snap_ec_q     <= '0;
            snap_noend_q  <= 1'b0;
            snap_miss_q   <= 1'b0;
            snap_ovf_q    <= 1'b0;
        end else begin
            do_err_prev_q <= bus.do_err;
            if (snap_take) begin
                snap_l1a_hi_q <= bus.l1a_num[23:12];
                snap_wc_q     <= wc_d;
                snap_ec_q     <= ec_d;
                snap_noend_q  <= noend_d;
                snap_miss_q   <= miss_d;
                snap_ovf_q    <= ovf_d;
                wc_q          <= '0;
                ec_q          <= '0;
                noend_q       <= 1'b0;
                miss_q        <= 1'b0;
                ovf_q         <= 1'b0;
            end else begin
                wc_q    <= wc_d;
                ec_q    <= ec_d;
                noend_q <= noend_d;
                miss_q  <= miss_d;
                ovf_q   <= ovf_d;
            end
        end
    end

    // W0 comes straight from L1A_NUM because the snapshot lands on the same edge.
    always_ff @(posedge clk_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            state_q     <= IDLE;
            tail_data_q <= '0;
            tail_vld_q  <= 1'b0;
            tail_last_q <= 1'b0;
            tail_busy_q <= 1'b0;
            tail_done_q <= 1'b0;
            tail_drop_q <= 1'b0;
        end else begin
            tail_done_q <= 1'b0;
            tail_drop_q <= bus.strt_tail && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (bus.strt_tail) begin
                        state_q     <= SEND0;
                        tail_data_q <= {4'hF, bus.l1a_num[11:0]};
                        tail_vld_q  <= 1'b1;
                        tail_busy_q <= 1'b1;
                    end
                end
                SEND0: begin
                    if (bus.out_rdy) begin
                        state_q     <= SEND1;
                        tail_data_q <= {4'hF, snap_l1a_hi_q};
                    end
                end
                SEND1: begin
                    if (bus.out_rdy) begin
                        state_q     <= SEND2;
                        tail_data_q <= {4'hE, snap_ec_q, snap_noend_q, snap_miss_q,
                                        snap_ovf_q, 5'b0};
                    end
                end
                SEND2: begin
                    if (bus.out_rdy) begin
                        state_q     <= SEND3;
                        tail_data_q <= {4'hE, snap_wc_q};
                        tail_last_q <= 1'b1;
                    end
                end
                SEND3: begin
                    if (bus.out_rdy) begin
                        state_q     <= DONE;
                        tail_data_q <= '0;
                        tail_vld_q  <= 1'b0;
                        tail_last_q <= 1'b0;
                        tail_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    tail_busy_q <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    tail_data_q <= '0;
                    tail_vld_q  <= 1'b0;
                    tail_last_q <= 1'b0;
                    tail_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tail_data = tail_data_q;
    assign bus.tail_vld  = tail_vld_q;
    assign bus.tail_last = tail_last_q;
    assign bus.tail_busy = tail_busy_q;
    assign bus.tail_done = tail_done_q;
    assign bus.tail_drop = tail_drop_q;

endmodule
